// File: rtl/adder_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the nibble-serial adder.
package adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width; a single-nibble adder still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/adder4bit.sv
// Combinational 4-bit adder stage with carry-in and carry-out.
module adder4bit
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] S,
  output logic             Cout
);

  // Widen operands by one bit so the carry lands in the MSB.
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{NIB_W{1'b0}}, Cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder that reuses one 4-bit stage, LSB nibble first, with handshakes.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NIB_W*NIBBLES-1:0] A,
  input  logic [NIB_W*NIBBLES-1:0] B,
  input  logic                     Cin,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NIB_W*NIBBLES-1:0] S,
  output logic                     Cout,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned W  = NIB_W * NIBBLES;
  localparam int unsigned CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] sum_nib;
  logic             sum_cout;

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_reg[i*NIB_W +: NIB_W];
        b_nib = b_reg[i*NIB_W +: NIB_W];
      end
    end
  end

  adder4bit u_add (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry),
    .S    (sum_nib),
    .Cout (sum_cout)
  );

  // The carry register is the final carry-out once the last nibble is done.
  assign Cout = carry;

  // Control FSM, operand/sum/carry registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      S         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= A;
            b_reg    <= B;
            carry    <= Cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NIBBLES); i++) begin
            if (cnt == CW'(i)) begin
              S[i*NIB_W +: NIB_W] <= sum_nib;
            end
          end
          carry <= sum_cout;
          // Stop on the last nibble so the counter never wraps.
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised checks of nibble_serial_adder at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] A4, B4, S4;
  logic        Cin4, Cout4, in_valid4, in_ready4, out_valid4, out_ready4;

  logic [3:0]  A1, B1, S1;
  logic        Cin1, Cout1, in_valid1, in_ready1, out_valid1, out_ready1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .A(A4), .B(B4), .Cin(Cin4),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .S(S4), .Cout(Cout4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .A(A1), .B(B1), .Cin(Cin1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .S(S1), .Cout(Cout1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One add on the 4-nibble instance with out_ready high; checks latency and result.
  task automatic add4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] exp_s, input logic exp_c);
    int n;
    n = 0;
    while (!in_ready4 && n < 50) begin step(); n++; end
    chk({tag, "_ready"}, 64'(in_ready4), 64'(1));
    A4 = a; B4 = b; Cin4 = cin; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    A4 = ~a; B4 = ~b; Cin4 = ~cin;
    n = 0;
    while (!out_valid4 && n < 20) begin step(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(4));
    chk({tag, "_s"}, 64'(S4), 64'(exp_s));
    chk({tag, "_c"}, 64'(Cout4), 64'(exp_c));
    step();
  endtask

  initial begin
    logic [16:0] model;
    logic [4:0]  model1;
    int          n;
    int          prev;

    rst = 1'b1;
    A4 = '0; B4 = '0; Cin4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    A1 = '0; B1 = '0; Cin1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready4), 64'(1));
    chk("rst_out_valid", 64'(out_valid4), 64'(0));
    chk("rst_s", 64'(S4), 64'(0));
    chk("rst_cout", 64'(Cout4), 64'(0));
    chk("rst1_in_ready", 64'(in_ready1), 64'(1));

    // Directed adds
    add4("add_1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    add4("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    add4("add_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    add4("add_max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Backpressure: result must hold while out_ready is low
    out_ready4 = 1'b0;
    A4 = 16'h1111; B4 = 16'h2222; Cin4 = 1'b0; in_valid4 = 1'b1;
    step();
    A4 = 16'h0005; B4 = 16'h0003;
    n = 0;
    while (!out_valid4 && n < 20) begin step(); n++; end
    chk("bp_lat", 64'(n), 64'(4));
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 64'(out_valid4), 64'(1));
      chk("bp_s", 64'(S4), 64'(16'h3333));
      chk("bp_c", 64'(Cout4), 64'(0));
      chk("bp_in_ready", 64'(in_ready4), 64'(0));
      step();
    end
    out_ready4 = 1'b1;
    step();
    chk("bp_release_in_ready", 64'(in_ready4), 64'(1));
    chk("bp_release_valid", 64'(out_valid4), 64'(0));
    step();
    chk("bp_second_accepted", 64'(in_ready4), 64'(0));
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin step(); n++; end
    chk("bp_second_s", 64'(S4), 64'(16'h0008));
    step();

    // Reset during the second RUN cycle
    A4 = 16'hFFFF; B4 = 16'h0001; Cin4 = 1'b1; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready4), 64'(1));
    chk("midrst_out_valid", 64'(out_valid4), 64'(0));
    chk("midrst_s", 64'(S4), 64'(0));
    chk("midrst_cout", 64'(Cout4), 64'(0));
    add4("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    // Back-to-back random adds, NIBBLES=4, valid/ready always high
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    A4 = 16'($urandom); B4 = 16'($urandom); Cin4 = 1'($urandom);
    prev = -1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!in_ready4 && n < 20) begin step(); n++; end
      model = {1'b0, A4} + {1'b0, B4} + {16'b0, Cin4};
      step();
      if (prev >= 0) chk("b2b4_spacing", 64'(cyc - prev), 64'(6));
      prev = cyc;
      n = 0;
      while (!out_valid4 && n < 20) begin step(); n++; end
      chk("b2b4_sum", 64'({Cout4, S4}), 64'(model));
      A4 = 16'($urandom); B4 = 16'($urandom); Cin4 = 1'($urandom);
    end
    in_valid4 = 1'b0;

    // Back-to-back random adds, NIBBLES=1
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    A1 = 4'($urandom); B1 = 4'($urandom); Cin1 = 1'($urandom);
    prev = -1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!in_ready1 && n < 20) begin step(); n++; end
      model1 = {1'b0, A1} + {1'b0, B1} + {4'b0, Cin1};
      step();
      if (prev >= 0) chk("b2b1_spacing", 64'(cyc - prev), 64'(3));
      prev = cyc;
      n = 0;
      while (!out_valid1 && n < 20) begin step(); n++; end
      chk("b2b1_lat", 64'(n), 64'(1));
      chk("b2b1_sum", 64'({Cout1, S1}), 64'(model1));
      A1 = 4'($urandom); B1 = 4'($urandom); Cin1 = 1'($urandom);
    end
    in_valid1 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
